// File: rtl/acc_pkg.sv
// Shared types and the saturating-add helper for the product frame accumulators.
package acc_pkg;

  typedef enum logic {ACCUM, HOLD} acc_state_t;

  localparam int SAT_MAX_W = 32;

  // Returns {ovf, sum}. The sum is clamped to 2^w-1 whenever the true sum needs more than w bits.
  function automatic logic [SAT_MAX_W:0] sat_add(input logic [SAT_MAX_W-1:0] a,
                                                 input logic [SAT_MAX_W-1:0] b,
                                                 input int unsigned w);
    logic [SAT_MAX_W:0]   full;
    logic [SAT_MAX_W-1:0] lim;
    full = {1'b0, a} + {1'b0, b};
    lim  = SAT_MAX_W'((33'(1) << w) - 33'(1));
    if ((full >> w) != '0) return {1'b1, lim};
    else                   return {1'b0, full[SAT_MAX_W-1:0]};
  endfunction

endpackage

// File: rtl/sat_adder_u.sv
// W-bit unsigned saturating adder, purely combinational.
module sat_adder_u
  import acc_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

  logic [SAT_MAX_W:0] res;

  assign res = sat_add(SAT_MAX_W'(a), SAT_MAX_W'(b), W);
  assign sum = res[W-1:0];
  // Bits above W are always zero; folding them in keeps every result bit consumed.
  assign ovf = res[SAT_MAX_W] | (|(res[SAT_MAX_W-1:0] >> W));

endmodule

// File: rtl/prod_frame_acc.sv
// Per-frame saturating sum of unsigned multiplier products, one registered result per frame.
module prod_frame_acc
  import acc_pkg::*;
#(
  parameter  int PROD_W  = 8,
  parameter  int ACC_W   = 16,
  parameter  int MAX_LEN = 64,
  localparam int CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_cnt,
  output logic              out_ovf,
  output logic              out_trunc
);

  acc_state_t       state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] add_sum;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             ovf;
  logic             add_ovf;
  logic             ovf_next;
  logic             accept;
  logic             close;

  // Handshake flags come straight from the state flop, so neither depends on an input.
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);

  // Once saturated, acc is all-ones and any further add clamps again, so saturation is sticky.
  sat_adder_u #(.W(ACC_W)) u_add (
    .a   (acc),
    .b   (ACC_W'(in_prod)),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  assign accept   = in_valid & in_ready;
  assign cnt_next = cnt + CNT_W'(1);
  assign ovf_next = ovf | add_ovf;
  assign close    = accept & (in_last | (cnt_next == CNT_W'(MAX_LEN)));

  // Accumulate stage -> result register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_sum   <= '0;
      out_cnt   <= '0;
      out_ovf   <= 1'b0;
      out_trunc <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (close) begin
            out_sum   <= add_sum;
            out_cnt   <= cnt_next;
            out_ovf   <= ovf_next;
            out_trunc <= ~in_last;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            state     <= HOLD;
          end else if (accept) begin
            acc <= add_sum;
            cnt <= cnt_next;
            ovf <= ovf_next;
          end
        end
        HOLD: begin
          if (out_ready) state <= ACCUM;
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_prod_frame_acc.sv
// Directed and randomized checks of prod_frame_acc across three parameterisations.
module tb_prod_frame_acc;

  function automatic int cfg_accw(int g);
    case (g)
      0:       return 10;
      default: return 16;
    endcase
  endfunction

  function automatic int cfg_maxl(int g);
    case (g)
      0:       return 64;
      1:       return 4;
      default: return 1;
    endcase
  endfunction

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       iv   = '0;
  logic [2:0][7:0]  ip   = '0;
  logic [2:0]       il   = '0;
  logic [2:0]       ordy = '0;
  wire  [2:0]       rdy_w;
  wire  [2:0]       vld_w;
  wire  [2:0][15:0] sum_w;
  wire  [2:0][7:0]  cnt_w;
  wire  [2:0]       ovf_w;
  wire  [2:0]       trn_w;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int AW = cfg_accw(g);
    localparam int ML = cfg_maxl(g);
    localparam int CW = $clog2(ML + 1);
    logic [AW-1:0] s;
    logic [CW-1:0] c;
    prod_frame_acc #(.PROD_W(8), .ACC_W(AW), .MAX_LEN(ML)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv[g]),
      .in_ready  (rdy_w[g]),
      .in_prod   (ip[g]),
      .in_last   (il[g]),
      .out_valid (vld_w[g]),
      .out_ready (ordy[g]),
      .out_sum   (s),
      .out_cnt   (c),
      .out_ovf   (ovf_w[g]),
      .out_trunc (trn_w[g])
    );
    assign sum_w[g] = 16'(s);
    assign cnt_w[g] = 8'(c);
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle on instance k; returns just after the rising edge.
  task automatic cycle(input int k, input bit v, input int p, input bit l, input bit r);
    @(negedge clk);
    iv[k] = v; ip[k] = 8'(p); il[k] = l; ordy[k] = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input int k, input bit v, input int s,
                         input int c, input bit o, input bit t);
    chk({tag, ".valid"}, 32'(vld_w[k]), 32'(v));
    chk({tag, ".ready"}, 32'(rdy_w[k]), 32'(!v));
    chk({tag, ".sum"},   32'(sum_w[k]), 32'(s));
    chk({tag, ".cnt"},   32'(cnt_w[k]), 32'(c));
    chk({tag, ".ovf"},   32'(ovf_w[k]), 32'(o));
    chk({tag, ".trunc"}, 32'(trn_w[k]), 32'(t));
  endtask

  task automatic do_reset();
    @(negedge clk);
    iv = '0; il = '0; ordy = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference: frame results from the rules (sum clamped, count, close reason).
  task automatic run_random(input int k, input int ncyc);
    int  maxv, maxl, tot, n;
    bit  pending, v, l, r;
    int  p, e_sum, e_cnt;
    bit  e_ovf, e_trn;
    maxv = (1 << cfg_accw(k)) - 1;
    maxl = cfg_maxl(k);
    tot = 0; n = 0; pending = 0;
    e_sum = 0; e_cnt = 0; e_ovf = 0; e_trn = 0;
    for (int i = 0; i < ncyc; i++) begin
      v = ($urandom % 4) != 0;
      p = (k == 0) ? $urandom_range(150, 255) : $urandom_range(0, 255);
      l = ($urandom % 6) == 0;
      r = ($urandom % 3) != 0;
      cycle(k, v, p, l, r);
      if (pending) begin
        if (r) pending = 0;
      end else if (v) begin
        tot += p;
        n++;
        if (l || n == maxl) begin
          e_sum = (tot > maxv) ? maxv : tot;
          e_ovf = tot > maxv;
          e_cnt = n;
          e_trn = !l;
          pending = 1;
          tot = 0; n = 0;
        end
      end
      chk("rand.valid", 32'(vld_w[k]), 32'(pending));
      chk("rand.ready", 32'(rdy_w[k]), 32'(!pending));
      if (pending) begin
        chk("rand.sum",   32'(sum_w[k]), 32'(e_sum));
        chk("rand.cnt",   32'(cnt_w[k]), 32'(e_cnt));
        chk("rand.ovf",   32'(ovf_w[k]), 32'(e_ovf));
        chk("rand.trunc", 32'(trn_w[k]), 32'(e_trn));
      end
    end
    cycle(k, 0, 0, 0, 1);
  endtask

  initial begin
    // Reset state on every instance
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) chk_out("reset", k, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Three beats closed by last
    cycle(1, 1, 10, 0, 1);
    cycle(1, 1, 20, 0, 1);
    chk("t1.mid_valid", 32'(vld_w[1]), 32'd0);
    cycle(1, 1, 30, 1, 1);
    chk_out("t1.res", 1, 1, 60, 3, 0, 0);
    cycle(1, 0, 0, 0, 1);
    chk_out("t1.after", 1, 0, 60, 3, 0, 0);

    // Saturation at ACC_W=10, then flags clear on the next frame
    for (int i = 0; i < 5; i++) cycle(0, 1, 225, i == 4, 1);
    chk_out("t2.sat", 0, 1, 1023, 5, 1, 0);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 1, 7, 1, 1);
    chk_out("t2.next", 0, 1, 7, 1, 0, 0);
    cycle(0, 0, 0, 0, 1);

    // Forced close at MAX_LEN=4 with the result held back
    for (int i = 0; i < 4; i++) cycle(1, 1, 1, 0, 0);
    chk_out("t3.trunc", 1, 1, 4, 4, 0, 1);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 1, 1, 0, 0);
      chk_out("t4.stall", 1, 1, 4, 4, 0, 1);
    end
    cycle(1, 1, 1, 0, 1);
    chk_out("t4.hshake", 1, 0, 4, 4, 0, 1);
    cycle(1, 1, 1, 0, 1);
    chk("t4.beat5_open", 32'(vld_w[1]), 32'd0);
    cycle(1, 1, 1, 1, 1);
    chk_out("t3.second", 1, 1, 2, 2, 0, 0);
    cycle(1, 0, 0, 0, 1);

    // Zero product, and MAX_LEN=1 close reasons
    cycle(1, 1, 0, 1, 1);
    chk_out("t5.zero", 1, 1, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 1);
    cycle(2, 1, 5, 1, 1);
    chk_out("t5.len1_last", 2, 1, 5, 1, 0, 0);
    cycle(2, 0, 0, 0, 1);
    cycle(2, 1, 9, 0, 1);
    chk_out("t5.len1_trunc", 2, 1, 9, 1, 0, 1);
    cycle(2, 0, 0, 0, 1);

    // Asynchronous reset mid-frame and mid-HOLD
    cycle(0, 1, 50, 0, 1);
    cycle(0, 1, 60, 0, 1);
    #2 rst_n = 1'b0;
    #1 chk_out("t6.midframe", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    iv = '0;
    rst_n = 1'b1;
    cycle(0, 1, 3, 1, 0);
    chk_out("t6.hold", 0, 1, 3, 1, 0, 0);
    #2 rst_n = 1'b0;
    #1 chk_out("t6.inhold", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    iv = '0;
    rst_n = 1'b1;
    cycle(0, 1, 4, 0, 1);
    cycle(0, 1, 5, 1, 1);
    chk_out("t6.post", 0, 1, 9, 2, 0, 0);
    cycle(0, 0, 0, 0, 1);

    // Randomized traffic against the frame model
    for (int k = 0; k < 3; k++) begin
      do_reset();
      run_random(k, 400);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
